sram_req_ctrl: RTL and testbench
================================

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, SRAM address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, SRAM word width.
REQ-003 SHALL have parameter RSP_DEPTH, default 2, response buffer entries (>=2).
REQ-004 SHALL have parameter INIT_VALUE, default all-zero, word written to every address during init.
REQ-005 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush_i, input, 1, pulse requesting array re-initialisation.
REQ-008 SHALL have port init_done_o, output, 1, high while in RUN.
REQ-009 SHALL have ports req_valid_i / req_ready_o, input / output, 1 each, request handshake.
REQ-010 SHALL have ports req_we_i (1), req_addr_i (ADDR_WIDTH), req_wdata_i (DATA_WIDTH) and req_be_i (DATA_WIDTH, per-bit write enable), all inputs.
REQ-011 SHALL have ports rsp_valid_o (out, 1), rsp_ready_i (in, 1) and rsp_rdata_o (out, DATA_WIDTH), read-response handshake.
REQ-012 SHALL have outputs mem_ce_o (1), mem_rdwen_o (1, 1=write), mem_a_o (ADDR_WIDTH), mem_di_o (DATA_WIDTH) and mem_bw_o (DATA_WIDTH, active-high); SHALL have input mem_do_i (DATA_WIDTH), valid the cycle after a read CE; all mem ports connect directly to the single-port RAM wrapper.

Function
REQ-013 SHALL implement FSM states INIT, RUN and DRAIN.
REQ-014 In INIT, SHALL hold req_ready_o=0 and issue one write per cycle: mem_ce_o=1, mem_rdwen_o=1, mem_bw_o all-ones, mem_di_o=INIT_VALUE, mem_a_o=init counter 0..DEPTH-1.
REQ-015 SHALL move INIT->RUN on the cycle after the write to address DEPTH-1; INIT takes exactly DEPTH cycles.
REQ-016 In RUN, a request transfers when req_valid_i && req_ready_o; the same cycle SHALL drive mem_ce_o=1, mem_rdwen_o=req_we_i, mem_a_o=req_addr_i, mem_di_o=req_wdata_i, mem_bw_o=req_be_i (write) or zero (read); no transfer SHALL give mem_ce_o=0.
REQ-017 Writes SHALL produce no response; reads SHALL push mem_do_i into the response FIFO on the following edge, making rsp_valid_o high 2 cycles after acceptance.
REQ-018 Outstanding = reads in flight (0/1) + FIFO occupancy; in RUN, req_ready_o SHALL be 1 when outstanding < RSP_DEPTH, or when outstanding == RSP_DEPTH and a response pops this cycle; it SHALL be independent of req_valid_i and req_we_i.
REQ-019 Back-to-back reads with rsp_ready_i held high SHALL sustain one read per cycle.
REQ-020 The response FIFO SHALL be in order; rsp_rdata_o SHALL be stable while rsp_valid_o && !rsp_ready_i; simultaneous push and pop SHALL leave occupancy unchanged; it SHALL never overflow.
REQ-021 flush_i in RUN SHALL move to DRAIN; a request presented in the same cycle SHALL NOT be accepted (req_ready_o is 0 that cycle).
REQ-022 In DRAIN, SHALL hold req_ready_o=0 and keep delivering responses; it SHALL move to INIT, with the counter cleared, once outstanding == 0.
REQ-023 flush_i in INIT or DRAIN SHALL be ignored.
REQ-024 init_done_o SHALL be 1 only in RUN.

Reset
REQ-025 rst_i SHALL asynchronously force INIT, init counter 0, FIFO empty, in-flight flag 0.
REQ-026 During reset, outputs SHALL be: req_ready_o=0, rsp_valid_o=0, init_done_o=0, mem_ce_o=0, mem_rdwen_o=0, mem_a_o/mem_di_o/mem_bw_o/rsp_rdata_o=0.
REQ-027 Reset mid-read SHALL discard in-flight and buffered responses; the first cycle after release SHALL issue the init write to address 0.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the default INIT_VALUE constant.
REQ-029 The response buffer SHALL be one sub-module, sram_rsp_fifo (parameterised width/depth, valid/ready on both sides).
REQ-030 The controller SHALL contain no RAM model; benches SHALL pair it with the behavioural single-port RAM.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-031 Reset release -> mem writes to addresses 0..15 with di=0x00 over 16 cycles; init_done_o rises at cycle 16; read of addr 7 returns 0x00.
REQ-032 Write addr 3 = 0xA5, be=0xFF; then write 0x0F with be=0x0F; read addr 3 -> rsp_rdata_o=0xAF, two cycles after acceptance.
REQ-033 Reads of addrs 0..5 back-to-back, rsp_ready_i=1 -> six responses in order on consecutive cycles, req_ready_o never drops.
REQ-034 rsp_ready_i=0, reads streamed -> exactly 2 accepted, req_ready_o=0, rsp_rdata_o stable; rsp_ready_i=1 -> ready returns the same cycle as the pop.
REQ-035 flush_i with one read in flight and one buffered -> DRAIN; both responses delivered; then 16 init cycles; earlier write of 0xA5 reads back 0x00.
REQ-036 Assert rst_i during the second of two outstanding reads -> rsp_valid_o=0 immediately, no stale response after release.

Source files
------------

// File: rtl/sram_req_ctrl_pkg.sv
// Shared types and constants for the SRAM request controller and its benches.
package sram_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

  localparam logic [127:0] INIT_VALUE_DEFAULT = '0;

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order response buffer; when full it still accepts a push in a cycle that pops.
module sram_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign out_valid_o = (count != '0);
  assign in_ready_o  = (count != FULL) || out_ready_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;
  // The head word is held until popped, so data stays stable under backpressure.
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM front end: clears the array after reset/flush, then serves
// reads and bit-masked writes with a bounded in-order read-response buffer.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    RSP_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  init_done_o,
  output ctrl_state_e           state_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [DATA_WIDTH-1:0] req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  mem_ce_o,
  output logic                  mem_rdwen_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0] mem_di_o,
  output logic [DATA_WIDTH-1:0] mem_bw_o,
  input  logic [DATA_WIDTH-1:0] mem_do_i
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W:0] OUT_MAX = (CNT_W + 1)'(RSP_DEPTH);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic                  req_fire;
  logic                  rsp_pop;
  logic                  fifo_in_ready;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        outstanding;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on valid, and a producer holds its payload while waiting.
  assign req_fire    = req_valid_i && req_ready_o;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign outstanding = {1'b0, fifo_count} + (CNT_W + 1)'(rd_inflight);
  assign state_o     = state;

  always_comb begin
    req_ready_o = 1'b0;
    if (state == ST_RUN && !flush_i && fifo_in_ready)
      req_ready_o = (outstanding < OUT_MAX) || (outstanding == OUT_MAX && rsp_pop);
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_rdwen_o = 1'b0;
    mem_a_o     = '0;
    mem_di_o    = '0;
    mem_bw_o    = '0;
    if (!rst_i) begin
      if (state == ST_INIT) begin
        mem_ce_o    = 1'b1;
        mem_rdwen_o = 1'b1;
        mem_a_o     = init_cnt;
        mem_di_o    = INIT_VALUE;
        mem_bw_o    = '1;
      end else if (req_fire) begin
        mem_ce_o    = 1'b1;
        mem_rdwen_o = req_we_i;
        mem_a_o     = req_addr_i;
        mem_di_o    = req_wdata_i;
        mem_bw_o    = req_we_i ? req_be_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
      init_done_o <= 1'b0;
    end else begin
      // Read data returns one cycle after the read strobe and lands in the FIFO.
      rd_inflight <= req_fire && !req_we_i;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == '1) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state       <= ST_DRAIN;
            init_done_o <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            state    <= ST_INIT;
            init_cnt <= '0;
          end
        end
        default: begin
          state       <= ST_INIT;
          init_cnt    <= '0;
          init_done_o <= 1'b0;
        end
      endcase
    end
  end

  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rd_inflight),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (mem_do_i),
    .out_valid_o (rsp_valid_o),
    .out_ready_i (rsp_ready_i),
    .out_data_o  (rsp_rdata_o),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl with a behavioural single-port RAM and a reference
// model made of a shadow memory array plus an expected-response queue.
module tb_sram_req_ctrl;
  import sram_req_ctrl_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          init_done;
  ctrl_state_e   state;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          mem_ce;
  logic          mem_rdwen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_bw;
  logic [DW-1:0] mem_do;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int acc_cnt   = 0;
  int rsp_cnt   = 0;
  int last_wait = 0;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            rsp_cyc_q[$];

  sram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .init_done_o (init_done),
    .state_o     (state),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .mem_ce_o    (mem_ce),
    .mem_rdwen_o (mem_rdwen),
    .mem_a_o     (mem_a),
    .mem_di_o    (mem_di),
    .mem_bw_o    (mem_bw),
    .mem_do_i    (mem_do)
  );

  // ---------------- clock / reset support ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural single-port RAM, read data valid the cycle after CE.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_rdwen) ram[mem_a] <= (ram[mem_a] & ~mem_bw) | (mem_di & mem_bw);
      else           mem_do     <= ram[mem_a];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Scoreboard: model accepted requests and compare every delivered response.
  always @(negedge clk) begin
    if (!rst) begin
      if (flush && init_done) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      if (req_valid && req_ready) begin
        acc_cnt++;
        if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_be) | (req_wdata & req_be);
        else        exp_q.push_back(ref_mem[req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        rsp_cyc_q.push_back(cyc);
        check("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] be);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    forever begin
      @(negedge clk);
      if (req_ready || n >= 50) break;
      n++;
      tick();
      if (n > 2) rsp_ready = 1'b1;
    end
    check("req_accept", 32'(n < 50), 1);
    last_wait = n;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_init_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!init_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 60), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int            n;
    int            t0;
    int            r0;
    int            a0;
    logic [DW-1:0] hold;

    rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    clear_model();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_outputs", {req_ready, rsp_valid, init_done, mem_ce, mem_rdwen}, 0);
    check("rst_mem_bus", {mem_a, mem_di, mem_bw, rsp_rdata}, 0);
    check("rst_state", 32'(state), 32'(ST_INIT));

    // Init sweep: one full-mask write of zero per cycle, then RUN at cycle 16
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_write", {mem_ce, mem_rdwen, mem_a, mem_di, mem_bw, req_ready, init_done},
            {1'b1, 1'b1, 4'(i), 8'h00, 8'hFF, 1'b0, 1'b0});
    end
    @(negedge clk);
    check("init_done_rise", {init_done, req_ready}, 2'b11);
    tick();
    rsp_ready = 1'b1;
    send(1'b0, 4'd7, 8'h00, 8'h00);
    repeat (3) tick();

    // Bit-masked write merge and read latency
    send(1'b1, 4'd3, 8'hA5, 8'hFF);
    send(1'b1, 4'd3, 8'h0F, 8'h0F);
    send(1'b0, 4'd3, 8'h00, 8'h00);
    @(negedge clk);
    check("rd_lat_cycle1", rsp_valid, 0);
    @(negedge clk);
    check("rd_lat_cycle2", {rsp_valid, rsp_rdata}, {1'b1, 8'hAF});
    tick();

    // Back-to-back reads at full rate
    for (int i = 0; i < 6; i++) send(1'b1, 4'(i), 8'($urandom), 8'hFF);
    repeat (3) tick();
    rsp_cyc_q.delete();
    r0 = rsp_cnt;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 4'(i), 8'h00, 8'h00);
      check("b2b_no_stall", last_wait, 0);
    end
    repeat (4) tick();
    check("b2b_count", rsp_cnt - r0, 6);
    check("b2b_consecutive", (rsp_cyc_q.size() >= 6) ? rsp_cyc_q[5] - rsp_cyc_q[0] : -1, 5);

    // Backpressure: exactly two reads accepted, head data held, ready returns on pop
    rsp_ready = 1'b0;
    a0 = acc_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'($urandom_range(0, 15));
    repeat (4) @(negedge clk);
    check("bp_accepted", acc_cnt - a0, 2);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    hold = rsp_rdata;
    repeat (2) @(negedge clk);
    check("bp_rdata_stable", rsp_rdata, hold);
    check("bp_still_two", acc_cnt - a0, 2);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_on_pop", req_ready, 1);
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("bp_drained", exp_q.size(), 0);

    // Flush with one read in flight and one buffered
    send(1'b1, 4'd9, 8'hA5, 8'hFF);
    rsp_ready = 1'b0;
    send(1'b0, 4'd2, 8'h00, 8'h00);
    send(1'b0, 4'd4, 8'h00, 8'h00);
    a0 = acc_cnt;
    r0 = rsp_cnt;
    flush = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'h55; req_be = 8'hFF;
    @(negedge clk);
    check("flush_blocks_req", req_ready, 0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_no_accept", acc_cnt - a0, 0);
    @(negedge clk);
    check("drain_state", {32'(state), init_done}, {32'(ST_DRAIN), 1'b0});
    tick();
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_ce && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_to_init", 32'(n < 40), 1);
    check("drain_rsp_count", rsp_cnt - r0, 2);
    t0 = cyc;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_init_done("reinit_done");
    check("reinit_length", cyc - t0, 16);
    tick();
    send(1'b0, 4'd9, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("flush_cleared", {rsp_valid, rsp_rdata}, {1'b1, 8'h00});
    tick();

    // Reset while a second read is still in flight
    rsp_ready = 1'b0;
    send(1'b0, 4'd5, 8'h00, 8'h00);
    send(1'b0, 4'd6, 8'h00, 8'h00);
    check("pre_rst_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_read", {rsp_valid, req_ready, mem_ce}, 3'b000);
    clear_model();
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_init_write", {mem_ce, mem_rdwen, mem_a}, {1'b1, 1'b1, 4'd0});
    wait_init_done("rst_reinit_done");
    check("no_stale_rsp", rsp_cnt - r0, 0);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    rsp_ready = 1'b1;
    repeat (8) tick();
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
